// File: rtl/sm3_adder_pipe.sv
// ============================================================================
// Module   : sm3_adder_pipe
// Brief    : Pipelined NUM_IN-operand modulo-2^WIDTH adder with valid/ready
//            handshake. Optional carry-out port: SM3_ADDER_PIPE_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm3_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_vld,
    output logic                     i_rdy,
    input  logic [NUM_IN*WIDTH-1:0]  i_data,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [WIDTH-1:0]         o_sum
`ifdef SM3_ADDER_PIPE_OVF_EN
    ,
    output logic [$clog2(NUM_IN)-1:0] o_ovf
`endif
);

`ifdef SM3_ADDER_PIPE_OVF_EN
    localparam int c_OVW = $clog2(NUM_IN);
    localparam int c_AW  = WIDTH + c_OVW;
`else
    localparam int c_AW  = WIDTH;
`endif

    // Operand k is folded into the partial sum at this stage; later stages
    // just carry it forward in the operand register.
    function automatic int stage_of(input int k);
        return (k * STAGES) / NUM_IN;
    endfunction

    logic [STAGES-1:0]        r_vld;
    logic [c_AW-1:0]          r_acc     [STAGES];
    logic [NUM_IN*WIDTH-1:0]  r_ops     [STAGES];

    logic [STAGES-1:0]        w_adv;
    logic [STAGES-1:0]        w_up_vld;
    logic [c_AW-1:0]          w_acc_src [STAGES];
    logic [NUM_IN*WIDTH-1:0]  w_ops_src [STAGES];
    logic [c_AW-1:0]          w_acc_nxt [STAGES];
    logic                     w_unused_ops;

    // A stage may advance if it is empty or everything downstream can move.
    always_comb begin
        logic t;
        t = o_rdy;
        for (int s = STAGES - 1; s >= 0; s--) begin
            t        = ~r_vld[s] | t;
            w_adv[s] = t;
        end
    end

    always_comb begin
        w_up_vld     = '0;
        w_up_vld[0]  = i_vld & ~i_clr;
        w_acc_src[0] = '0;
        w_ops_src[0] = i_data;
        for (int s = 1; s < STAGES; s++) begin
            w_up_vld[s]  = r_vld[s-1];
            w_acc_src[s] = r_acc[s-1];
            w_ops_src[s] = r_ops[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_acc_nxt[s] = w_acc_src[s];
            for (int k = 0; k < NUM_IN; k++) begin
                if (stage_of(k) == s) begin
                    w_acc_nxt[s] = w_acc_nxt[s] + c_AW'(w_ops_src[s][k*WIDTH +: WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_acc[s] <= '0;
                r_ops[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (i_clr) begin
                    r_vld[s] <= 1'b0;
                end else if (w_adv[s]) begin
                    r_vld[s] <= w_up_vld[s];
                end
                if (w_adv[s] && w_up_vld[s] && !i_clr) begin
                    r_acc[s] <= w_acc_nxt[s];
                    r_ops[s] <= w_ops_src[s];
                end
            end
        end
    end

    // The last stage has no consumer for its operand copy.
    assign w_unused_ops = ^r_ops[STAGES-1];

    assign i_rdy = rst_n & ~i_clr & w_adv[0];
    assign o_vld = r_vld[STAGES-1];
    assign o_sum = r_acc[STAGES-1][WIDTH-1:0];

`ifdef SM3_ADDER_PIPE_OVF_EN
    assign o_ovf = r_acc[STAGES-1][c_AW-1:WIDTH];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sm3_adder_pipe.sv
// ============================================================================
// Module   : tb_sm3_adder_pipe
// Brief    : Directed self-checking bench for sm3_adder_pipe (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm3_adder_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int STAGES = 2;

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b0;
    logic                    i_clr  = 1'b0;
    logic                    i_vld  = 1'b0;
    logic                    o_rdy  = 1'b0;
    logic [NUM_IN*WIDTH-1:0] i_data = '0;
    logic                    i_rdy;
    logic                    o_vld;
    logic [WIDTH-1:0]        o_sum;
`ifdef SM3_ADDER_PIPE_OVF_EN
    logic [1:0]              o_ovf;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    sm3_adder_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .STAGES (STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (i_clr),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .i_data (i_data),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy),
        .o_sum  (o_sum)
`ifdef SM3_ADDER_PIPE_OVF_EN
        ,
        .o_ovf  (o_ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [95:0] d);
        return d[31:0] + d[63:32] + d[95:64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_o_vld got=%b want=0", o_vld); end
        checks++; if (o_sum !== 32'h0) begin errors++; $display("FAIL reset_o_sum got=%h want=0", o_sum); end
        checks++; if (i_rdy !== 1'b0) begin errors++; $display("FAIL reset_i_rdy got=%b want=0", i_rdy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_i_rdy got=%b want=1", i_rdy); end
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL post_reset_o_vld got=%b want=0", o_vld); end
    endtask

    task automatic test_basic();
        i_data = {32'd3, 32'd2, 32'd1};
        i_vld  = 1'b1;
        o_rdy  = 1'b1;
        #1;
        checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL basic_i_rdy got=%b want=1", i_rdy); end
        tick();
        i_vld = 1'b0;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL basic_early_vld got=%b want=0", o_vld); end
        tick();
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL basic_latency_vld got=%b want=1", o_vld); end
        checks++; if (o_sum !== 32'h6) begin errors++; $display("FAIL basic_sum got=%h want=00000006", o_sum); end
`ifdef SM3_ADDER_PIPE_OVF_EN
        checks++; if (o_ovf !== 2'd0) begin errors++; $display("FAIL basic_ovf got=%0d want=0", o_ovf); end
`endif
        tick();
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL basic_single_result got=%b want=0", o_vld); end
    endtask

    task automatic test_wrap();
        i_data = {96{1'b1}};
        i_vld  = 1'b1;
        o_rdy  = 1'b1;
        tick();
        i_vld = 1'b0;
        tick();
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL wrap_vld got=%b want=1", o_vld); end
        checks++; if (o_sum !== 32'hFFFF_FFFD) begin errors++; $display("FAIL wrap_sum got=%h want=fffffffd", o_sum); end
`ifdef SM3_ADDER_PIPE_OVF_EN
        checks++; if (o_ovf !== 2'd2) begin errors++; $display("FAIL wrap_ovf got=%0d want=2", o_ovf); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        int          n_in;
        int          n_out;
        logic [95:0] v;
        logic [31:0] e;
        n_in  = 0;
        n_out = 0;
        exp_q.delete();
        o_rdy = 1'b1;
        for (int cyc = 0; cyc < 20 + STAGES + 4; cyc++) begin
            if (o_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_result got=%h want=none", o_sum);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (o_sum !== e) begin errors++; $display("FAIL b2b_sum#%0d got=%h want=%h", n_out, o_sum, e); end
                end
            end
            if (n_in < 20) begin
                v      = {$urandom(), $urandom(), $urandom()};
                i_data = v;
                i_vld  = 1'b1;
                #1;
                checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL b2b_i_rdy cyc=%0d got=%b want=1", cyc, i_rdy); end
                if (i_rdy) begin
                    exp_q.push_back(model(v));
                    n_in++;
                end
            end else begin
                i_vld = 1'b0;
            end
            tick();
        end
        checks++; if (n_out !== 20) begin errors++; $display("FAIL b2b_count got=%0d want=20", n_out); end
    endtask

    task automatic test_backpressure();
        int          n_acc;
        int          n_out;
        logic        have;
        logic [31:0] held;
        logic [95:0] v;
        logic [31:0] e;
        n_acc = 0;
        n_out = 0;
        have  = 1'b0;
        held  = '0;
        exp_q.delete();
        o_rdy = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (o_vld) begin
                if (!have) begin
                    held = o_sum;
                    have = 1'b1;
                end else begin
                    checks++; if (o_sum !== held) begin errors++; $display("FAIL bp_stable got=%h want=%h", o_sum, held); end
                end
            end
            v      = {32'h1000 + 32'(cyc), 32'h200, 32'h30};
            i_data = v;
            i_vld  = 1'b1;
            #1;
            if (i_rdy) begin
                exp_q.push_back(model(v));
                n_acc++;
            end
            tick();
        end
        checks++; if (n_acc !== STAGES) begin errors++; $display("FAIL bp_accepted got=%0d want=%0d", n_acc, STAGES); end
        checks++; if (i_rdy !== 1'b0) begin errors++; $display("FAIL bp_i_rdy_full got=%b want=0", i_rdy); end
        checks++; if (o_sum !== 32'h1230) begin errors++; $display("FAIL bp_head_sum got=%h want=00001230", o_sum); end
        i_vld = 1'b0;
        o_rdy = 1'b1;
        for (int cyc = 0; cyc < STAGES + 4; cyc++) begin
            if (o_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_duplicate got=%h want=none", o_sum);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (o_sum !== e) begin errors++; $display("FAIL bp_drain_sum got=%h want=%h", o_sum, e); end
                end
            end
            tick();
        end
        checks++; if (n_out !== STAGES) begin errors++; $display("FAIL bp_drain_count got=%0d want=%0d", n_out, STAGES); end
    endtask

    task automatic test_flush();
        int          n_acc;
        int          n_in;
        int          n_out;
        logic [95:0] v;
        logic [31:0] e;
        n_acc = 0;
        exp_q.delete();
        o_rdy = 1'b0;
        for (int cyc = 0; cyc < 6 && n_acc < STAGES; cyc++) begin
            i_data = {32'h5, 32'h6, 32'h7 + 32'(cyc)};
            i_vld  = 1'b1;
            #1;
            if (i_rdy) n_acc++;
            tick();
        end
        i_clr  = 1'b1;
        i_vld  = 1'b1;
        i_data = {32'hDEAD, 32'hBEEF, 32'h1};
        #1;
        checks++; if (i_rdy !== 1'b0) begin errors++; $display("FAIL flush_i_rdy got=%b want=0", i_rdy); end
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL flush_full_vld got=%b want=1", o_vld); end
        tick();
        i_clr = 1'b0;
        i_vld = 1'b0;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL flush_o_vld got=%b want=0", o_vld); end
        o_rdy = 1'b1;
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 3 + STAGES + 4; cyc++) begin
            if (o_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL flush_stale_result got=%h want=none", o_sum);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (o_sum !== e) begin errors++; $display("FAIL flush_after_sum got=%h want=%h", o_sum, e); end
                end
            end
            if (n_in < 3) begin
                v      = {32'h100 * 32'(n_in + 1), 32'h11, 32'h22};
                i_data = v;
                i_vld  = 1'b1;
                #1;
                if (i_rdy) begin
                    exp_q.push_back(model(v));
                    n_in++;
                end
            end else begin
                i_vld = 1'b0;
            end
            tick();
        end
        checks++; if (n_out !== 3) begin errors++; $display("FAIL flush_after_count got=%0d want=3", n_out); end
    endtask

    task automatic test_async_reset();
        o_rdy = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            i_data = {32'h7, 32'h8, 32'h9 + 32'(cyc)};
            i_vld  = 1'b1;
            tick();
        end
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL areset_pre_vld got=%b want=1", o_vld); end
        #2;
        rst_n = 1'b0;
        i_vld = 1'b0;
        #1;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL areset_o_vld got=%b want=0", o_vld); end
        checks++; if (o_sum !== 32'h0) begin errors++; $display("FAIL areset_o_sum got=%h want=0", o_sum); end
        checks++; if (i_rdy !== 1'b0) begin errors++; $display("FAIL areset_i_rdy got=%b want=0", i_rdy); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        i_data = {32'h30, 32'h20, 32'h10};
        i_vld  = 1'b1;
        #1;
        checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL areset_restart_rdy got=%b want=1", i_rdy); end
        tick();
        i_vld = 1'b0;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL areset_early_vld got=%b want=0", o_vld); end
        tick();
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL areset_result_vld got=%b want=1", o_vld); end
        checks++; if (o_sum !== 32'h60) begin errors++; $display("FAIL areset_result_sum got=%h want=00000060", o_sum); end
        tick();
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL areset_no_stale got=%b want=0", o_vld); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm3_adder_pipe.md
Name: sm3_adder_pipe

Overview:
- Parametrised, pipelined multi-operand modular adder for the SM3 compression datapath.
- Successor to the fixed 3-input 32-bit combinational adder.
- Sums NUM_IN operands of WIDTH bits modulo 2^WIDTH over STAGES register stages, with valid/ready handshake on both sides.
- Used wherever the round logic needs wide additions (e.g. TT1/TT2) split across clock cycles to close timing.

Parameters:
WIDTH, 32, operand and result width in bits (8..64).
NUM_IN, 3, number of operands summed (2..8).
STAGES, 2, pipeline register stages = latency in cycles (1..4).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
i_clr  input  1  synchronous flush; invalidates all stages.
i_vld  input  1  input operands valid.
i_rdy  output  1  block can accept input this cycle.
i_data  input  NUM_IN*WIDTH  packed operands; operand k at [k*WIDTH +: WIDTH].
o_vld  output  1  result valid.
o_rdy  input  1  downstream accepts result.
o_sum  output  WIDTH  (sum of all operands) mod 2^WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0. o_vld=0, o_sum=0, i_rdy=0 while rst_n low; i_rdy follows the rules below from the first clock after release.
- Arithmetic: unsigned, carries beyond bit WIDTH-1 discarded. Reduction tree partitioned across the STAGES register boundaries; intermediate sums carried at WIDTH bits (mod arithmetic is associative, so truncation is exact).
- Stage s holds vld[s] and a data register; stage STAGES-1 drives o_vld/o_sum directly from registers (no combinational input-to-output path).
- Advance rule: adv[STAGES-1] = ~vld[STAGES-1] | o_rdy; adv[s] = ~vld[s] | adv[s+1]. Bubbles collapse.
- i_rdy = adv[0] & ~i_clr. Transfer in when i_vld & i_rdy. Transfer out when o_vld & o_rdy.
- Latency: result of an accepted input appears on o_vld exactly STAGES cycles later if never stalled. Throughput is one result per cycle with o_rdy held high.
- A stalled stage holds its data; o_sum stable while o_vld=1 & o_rdy=0.
- When a stage is not loading, its data register holds. o_sum keeps its last value when o_vld=0.
- i_clr: next edge clears all vld bits; data registers need not clear. i_clr has priority over a simultaneous i_vld, which is not accepted (i_rdy=0). A result presented with o_rdy in the i_clr cycle still counts as transferred.
- Full pipeline with o_rdy=0: i_rdy=0. If o_rdy rises, i_rdy rises combinationally in that cycle (full-rate restart).
- Reset mid-operation: all in-flight results discarded, no partial output.

Optional Feature:
- Macro: SM3_ADDER_PIPE_OVF_EN.
- Defined: extra port o_ovf, output, width clog2(NUM_IN), registered alongside o_sum. o_ovf = bits above WIDTH-1 of the exact sum (the carry-out count), 0 at reset.
- Not defined: port absent; overflow bits not computed. o_sum is identical in both builds.

Test Plan:
- Defaults, operands 0x00000001, 0x00000002, 0x00000003, o_rdy=1 -> o_vld exactly 2 cycles after accept, o_sum=0x00000006.
- Wrap: NUM_IN=3, all operands 0xFFFFFFFF -> o_sum=0xFFFFFFFD. With SM3_ADDER_PIPE_OVF_EN, o_ovf=2.
- Back-to-back stream: 20 random vectors, i_vld=1 and o_rdy=1 every cycle -> i_rdy never drops, 20 in-order results matching the model, one per cycle.
- Backpressure: o_rdy=0 for 5 cycles while feeding -> accepts exactly STAGES inputs then i_rdy=0; o_sum stable. After o_rdy=1, all results emerge in order with none lost or duplicated.
- Flush: pipeline full, assert i_clr for 1 cycle with i_vld=1 -> o_vld=0 next cycle, that input not accepted, later inputs produce correct sums.
- Async reset mid-stream: pull rst_n low between clock edges -> o_vld and o_sum go to 0 immediately. After release, the first new input's result (0x10+0x20+0x30 -> 0x60) arrives after STAGES cycles.
